ram_word_engine: RTL and testbench

Parametrised successor to the byte-RAM read and write word assemblers under the main control state machine. It moves bursts of 1..MAX_BURST words, each WORD_BYTES bytes wide, between the command state machine and a byte-wide dual-port RAM with separately clocked read and write sides. Byte order is selectable per transfer. It also provides:
- rejection of out-of-range requests;
- one queued start for a read and write issued together.

---
 rtl/ram_word_pkg.sv | 23 ++
 rtl/ram_byte_phase.sv | 22 ++
 rtl/ram_word_engine.sv | 189 ++++++++++++++++++
 tb/tb_ram_word_engine.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_word_pkg.sv
// Shared types and helpers for the byte-RAM word engine.
package ram_word_pkg;

  typedef enum logic [3:0] {
    IDLE, RD_ADDR, RD_CLK, RD_CAP, RD_WORD,
    WR_REQ, WR_LOAD, WR_ADDR, WR_CLK, WR_END, DONE
  } state_t;

  typedef enum logic {LITTLE = 1'b0, BIG = 1'b1} endian_t;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Word lane that holds byte k of a word in the given byte order.
  function automatic int lane_index(input int k, input endian_t endian, input int word_bytes);
    return (endian == BIG) ? (word_bytes - 1 - k) : k;
  endfunction

endpackage

// File: rtl/ram_byte_phase.sv
// Three-cycle byte access sequencer: address, RAM clock high, capture/strobe end.
module ram_byte_phase (
  input  logic clk,
  input  logic reset,
  input  logic byte_go,
  output logic ram_clock,
  output logic byte_done
);
  localparam int STAGES = 2;

  // One-hot phase: [0] address set-up, [1] RAM clock high, [2] clock low / finish.
  logic [STAGES:0] vld_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:0], byte_go};
  end

  assign ram_clock = vld_pipe[1];
  assign byte_done = vld_pipe[STAGES];

endmodule

// File: rtl/ram_word_engine.sv
// Burst word read/write engine between the command FSM and a byte-wide dual-port RAM.
module ram_word_engine
  import ram_word_pkg::*;
#(
  parameter  int NUMBER     = 256,
  parameter  int WORD_BYTES = 4,
  parameter  int MAX_BURST  = 8,
  localparam int AW         = clogb2(NUMBER),
  localparam int WW         = 8 * WORD_BYTES,
  localparam int CW         = clogb2(MAX_BURST + 1)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_start,
  input  logic [AW-1:0] rd_base,
  input  logic [CW-1:0] rd_count,
  output logic [WW-1:0] rd_word,
  output logic          rd_word_valid,
  output logic          rd_done,
  input  logic          wr_start,
  input  logic [AW-1:0] wr_base,
  input  logic [CW-1:0] wr_count,
  output logic          wr_word_req,
  input  logic [WW-1:0] wr_word,
  output logic          wr_done,
  input  logic          big_endian,
  output logic          busy,
  output logic          error,
  input  logic [7:0]    ram_rd_data,
  output logic [AW-1:0] ram_rd_addr,
  output logic          ram_rd_clock,
  output logic [7:0]    ram_wr_data,
  output logic [AW-1:0] ram_wr_addr,
  output logic          ram_wr_clock,
  output logic          ram_we
);
  localparam int BW = (WORD_BYTES > 1) ? clogb2(WORD_BYTES) : 1;
  localparam int SW = AW + CW + clogb2(WORD_BYTES) + 1;
  localparam logic [BW-1:0] LAST_B = BW'(WORD_BYTES - 1);

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] base;
    logic [CW-1:0] count;
    endian_t       endian;
  } pend_t;

  // Sum is wide enough that base + count*WORD_BYTES can never wrap.
  function automatic logic start_ok(input logic [AW-1:0] base, input logic [CW-1:0] count);
    logic [SW-1:0] lim;
    lim = SW'(base) + SW'(count) * SW'(WORD_BYTES);
    return (count != '0) && (SW'(count) <= SW'(MAX_BURST)) && (lim <= SW'(NUMBER));
  endfunction

  state_t  state, state_nxt;
  pend_t   pend;
  endian_t endian_q, in_endian, l_endian, g_end;

  logic [AW-1:0] addr, l_base, g_addr;
  logic [BW-1:0] byte_idx, cur_lane, g_bidx, g_lane;
  logic [CW-1:0] words_left, l_count;
  logic          cur_last, error_q;
  logic [WORD_BYTES-1:0][7:0] wr_buf, wr_src, rd_buf, rd_nxt;

  logic wr_ok, rd_ok, acc_wr, acc_rd, queue_rd, last_word, err;
  logic rd_go, wr_go, launch, rd_byte_done, wr_byte_done;

  assign in_endian = endian_t'(big_endian);
  assign wr_ok     = start_ok(wr_base, wr_count);
  assign rd_ok     = start_ok(rd_base, rd_count);
  // A write wins a simultaneous start; a valid read then waits in the pending slot.
  assign acc_wr    = (state == IDLE) && wr_start && wr_ok;
  assign acc_rd    = (state == IDLE) && rd_start && rd_ok && !acc_wr;
  assign queue_rd  = acc_wr && rd_start && rd_ok;
  assign last_word = (words_left == CW'(1));
  assign err       = (state == IDLE) ? ((wr_start && !wr_ok) || (rd_start && !rd_ok))
                                     : (wr_start || rd_start);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc_wr) state_nxt = WR_REQ;
               else if (acc_rd) state_nxt = RD_ADDR;
      RD_ADDR: state_nxt = RD_CLK;
      RD_CLK:  state_nxt = RD_CAP;
      RD_CAP:  if (rd_byte_done) state_nxt = cur_last ? RD_WORD : RD_ADDR;
      RD_WORD: state_nxt = last_word ? IDLE : RD_ADDR;
      WR_REQ:  state_nxt = WR_LOAD;
      WR_LOAD: state_nxt = WR_ADDR;
      WR_ADDR: state_nxt = WR_CLK;
      WR_CLK:  state_nxt = WR_END;
      WR_END:  if (wr_byte_done) state_nxt = !cur_last ? WR_ADDR : (last_word ? DONE : WR_REQ);
      DONE:    state_nxt = pend.vld ? RD_ADDR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte launch: a new read takes its parameters straight from the start inputs
  // or the pending slot; later bytes continue from the running counters.
  always_comb begin
    rd_go    = (state_nxt == RD_ADDR);
    wr_go    = (state_nxt == WR_ADDR);
    launch   = rd_go && ((state == IDLE) || (state == DONE));
    l_base   = (state == IDLE) ? rd_base  : pend.base;
    l_count  = (state == IDLE) ? rd_count : pend.count;
    l_endian = (state == IDLE) ? in_endian : pend.endian;
    g_addr   = launch ? l_base : addr;
    g_bidx   = launch ? '0 : byte_idx;
    g_end    = launch ? l_endian : endian_q;
    g_lane   = BW'(lane_index(int'(g_bidx), g_end, WORD_BYTES));
    wr_src   = (state == WR_LOAD) ? wr_word : wr_buf;
    rd_nxt   = rd_buf;
    if ((state == RD_CAP) && rd_byte_done) rd_nxt[cur_lane] = ram_rd_data;
  end

  ram_byte_phase u_rd_phase (
    .clk(clk), .reset(reset), .byte_go(rd_go),
    .ram_clock(ram_rd_clock), .byte_done(rd_byte_done)
  );

  ram_byte_phase u_wr_phase (
    .clk(clk), .reset(reset), .byte_go(wr_go),
    .ram_clock(ram_wr_clock), .byte_done(wr_byte_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pend        <= '0;
      endian_q    <= LITTLE;
      addr        <= '0;
      byte_idx    <= '0;
      cur_lane    <= '0;
      cur_last    <= 1'b0;
      words_left  <= '0;
      wr_buf      <= '0;
      rd_buf      <= '0;
      rd_word     <= '0;
      error_q     <= 1'b0;
      ram_rd_addr <= '0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_we      <= 1'b0;
    end else begin
      state   <= state_nxt;
      error_q <= err;
      ram_we  <= (state_nxt == WR_ADDR) || (state_nxt == WR_CLK);
      if (acc_wr) begin
        addr       <= wr_base;
        byte_idx   <= '0;
        words_left <= wr_count;
        endian_q   <= in_endian;
      end
      if (queue_rd) pend <= '{vld: 1'b1, base: rd_base, count: rd_count, endian: in_endian};
      if (launch) begin
        words_left <= l_count;
        endian_q   <= l_endian;
        pend.vld   <= 1'b0;
      end
      if (rd_go || wr_go) begin
        addr     <= g_addr + 1'b1;
        byte_idx <= (g_bidx == LAST_B) ? '0 : g_bidx + 1'b1;
        cur_lane <= g_lane;
        cur_last <= (g_bidx == LAST_B);
      end
      if (rd_go) ram_rd_addr <= g_addr;
      if (wr_go) begin
        ram_wr_addr <= g_addr;
        ram_wr_data <= wr_src[g_lane];
      end
      if (state == WR_LOAD) wr_buf <= wr_word;
      if ((state == RD_CAP) && rd_byte_done) begin
        rd_buf <= rd_nxt;
        if (cur_last) rd_word <= rd_nxt;
      end
      if (((state == RD_WORD) && !last_word) ||
          ((state == WR_END) && wr_byte_done && cur_last && !last_word))
        words_left <= words_left - 1'b1;
    end
  end

  assign rd_word_valid = (state == RD_WORD);
  assign rd_done       = (state == RD_WORD) && last_word;
  assign wr_word_req   = (state == WR_REQ);
  assign wr_done       = (state == DONE);
  assign error         = error_q;
  assign busy          = !((state == IDLE) || (state == DONE) || ((state == RD_WORD) && last_word));

endmodule

// File: tb/tb_ram_word_engine.sv
// Directed bench for ram_word_engine with a byte RAM model and a read-word scoreboard.
module tb_ram_word_engine;
  localparam int AW = 8;
  localparam int CW = 4;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_start, wr_start, big_endian;
  logic [AW-1:0] rd_base, wr_base;
  logic [CW-1:0] rd_count, wr_count;
  logic [WW-1:0] rd_word, wr_word;
  logic          rd_word_valid, rd_done, wr_word_req, wr_done, busy, error;
  logic [7:0]    ram_rd_data, ram_wr_data;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic          ram_rd_clock, ram_wr_clock, ram_we;

  always #5 clk = ~clk;

  ram_word_engine dut (
    .clk(clk), .reset(reset),
    .rd_start(rd_start), .rd_base(rd_base), .rd_count(rd_count),
    .rd_word(rd_word), .rd_word_valid(rd_word_valid), .rd_done(rd_done),
    .wr_start(wr_start), .wr_base(wr_base), .wr_count(wr_count),
    .wr_word_req(wr_word_req), .wr_word(wr_word), .wr_done(wr_done),
    .big_endian(big_endian), .busy(busy), .error(error),
    .ram_rd_data(ram_rd_data), .ram_rd_addr(ram_rd_addr), .ram_rd_clock(ram_rd_clock),
    .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_clock(ram_wr_clock),
    .ram_we(ram_we)
  );

  logic [7:0] mem [256];
  always @(posedge ram_rd_clock) ram_rd_data <= mem[ram_rd_addr];
  always @(posedge ram_wr_clock) if (ram_we) mem[ram_wr_addr] = ram_wr_data;

  int rclk_n = 0, wclk_n = 0, we_bad = 0;
  int tests = 0, fails = 0;
  logic prev_wclk = 1'b0;
  logic [WW-1:0] exp_q [$];

  always @(posedge ram_rd_clock) rclk_n++;
  always @(posedge ram_wr_clock) wclk_n++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for assembled words; also flags write-enable left high once the write clock falls.
  always @(negedge clk) begin
    if (prev_wclk && !ram_wr_clock && ram_we) we_bad++;
    prev_wclk = ram_wr_clock;
    if (!reset && rd_word_valid) begin
      if (exp_q.size() == 0) chk("rd_word_extra", 64'(rd_word_valid), 64'd0);
      else chk("rd_word", 64'(rd_word), 64'(exp_q.pop_front()));
    end
  end

  task automatic pulse_start(input logic do_rd, input logic do_wr,
                             input logic [AW-1:0] rb, input logic [CW-1:0] rc,
                             input logic [AW-1:0] wb, input logic [CW-1:0] wc,
                             input logic be);
    rd_start = do_rd; rd_base = rb; rd_count = rc;
    wr_start = do_wr; wr_base = wb; wr_count = wc;
    big_endian = be;
    @(negedge clk);
    rd_start = 1'b0; wr_start = 1'b0;
  endtask

  // Cycle numbering: cycle 1 is the cycle after the accepting edge.
  task automatic wait_rd(input int c0, output int cyc);
    cyc = c0;
    while (!rd_done && cyc < c0 + 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_wr(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                        output int nreq, output int done_cyc);
    nreq = 0; done_cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      if (wr_word_req) begin
        wr_word = (nreq == 0) ? w0 : w1;
        nreq++;
      end
      if (wr_done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc, nreq, dc, r0, w0;
    logic [63:0] m;
    logic [AW-1:0] bad_base [3];
    logic [CW-1:0] bad_cnt [3];
    logic          bad_rd [3];
    bad_base = '{8'hFD, 8'h10, 8'h00};
    bad_cnt  = '{4'd1, 4'd0, 4'd9};
    bad_rd   = '{1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rd_start = 0; wr_start = 0; big_endian = 0; wr_word = '0;
    rd_base = '0; wr_base = '0; rd_count = '0; wr_count = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 64'({busy, error, rd_word_valid, rd_done, wr_word_req, wr_done,
                           ram_we, ram_rd_clock, ram_wr_clock}), 64'd0);
    chk("reset_data", {rd_word, ram_rd_addr, ram_wr_addr, ram_wr_data, 8'h00}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Little-endian single-word read
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    exp_q.push_back(32'h44332211);
    pulse_start(1, 0, 8'h10, 1, 0, 0, 0);
    chk("le_busy_c1", 64'(busy), 64'd1);
    wait_rd(1, cyc);
    chk("le_latency", 64'(cyc), 64'd13);
    chk("le_done_cycle", 64'({busy, rd_word_valid}), 64'b01);
    @(negedge clk);
    chk("le_word_hold", 64'({rd_word_valid, rd_word}), 64'h0_4433_2211);

    // Big-endian two-word write, then read back in both byte orders
    we_bad = 0;
    pulse_start(0, 1, 0, 0, 8'h20, 2, 1);
    run_wr(32'hA1B2C3D4, 32'h01020304, nreq, dc);
    chk("be_wr_reqs", 64'(nreq), 64'd2);
    chk("be_wr_done_cycle", 64'(dc), 64'd29);
    @(negedge clk);
    chk("be_wr_done_single", 64'(wr_done), 64'd0);
    m = '0;
    for (int i = 0; i < 8; i++) m = {m[55:0], mem[32 + i]};
    chk("be_wr_mem", m, 64'hA1B2C3D4_01020304);
    chk("be_we_in_wr_end", 64'(we_bad), 64'd0);
    exp_q.push_back(32'hA1B2C3D4);
    exp_q.push_back(32'h01020304);
    pulse_start(1, 0, 8'h20, 2, 0, 0, 1);
    wait_rd(1, cyc);
    chk("be_rd_latency", 64'(cyc), 64'd26);
    @(negedge clk);

    // Last legal word of the RAM
    mem[8'hFC] = 8'h5A; mem[8'hFD] = 8'h6B; mem[8'hFE] = 8'h7C; mem[8'hFF] = 8'h8D;
    exp_q.push_back(32'h8D7C6B5A);
    pulse_start(1, 0, 8'hFC, 1, 0, 0, 0);
    wait_rd(1, cyc);
    chk("edge_rd_latency", 64'(cyc), 64'd13);
    @(negedge clk);

    // Rejected starts: out of range, zero count, oversized burst
    for (int i = 0; i < 3; i++) begin
      r0 = rclk_n; w0 = wclk_n;
      pulse_start(bad_rd[i], !bad_rd[i], bad_base[i], bad_cnt[i], bad_base[i], bad_cnt[i], 0);
      chk($sformatf("reject%0d_err", i), 64'({error, busy}), 64'b10);
      repeat (4) @(negedge clk);
      chk($sformatf("reject%0d_quiet", i),
          64'({error, busy, wr_word_req, 8'(rclk_n - r0), 8'(wclk_n - w0)}), 64'd0);
    end

    // Simultaneous write + read of the same word
    exp_q.push_back(32'hCAFEF00D);
    pulse_start(1, 1, 8'h40, 1, 8'h40, 1, 0);
    chk("simul_no_err", 64'(error), 64'd0);
    run_wr(32'hCAFEF00D, 32'h0, nreq, dc);
    chk("simul_wr_done_cycle", 64'(dc), 64'd15);
    wait_rd(dc, cyc);
    chk("simul_rd_done_cycle", 64'(cyc), 64'd28);
    @(negedge clk);

    // Start while busy is rejected; the read in flight is unaffected
    exp_q.push_back(32'hD4C3B2A1);
    w0 = wclk_n;
    pulse_start(1, 0, 8'h20, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    pulse_start(0, 1, 0, 0, 8'h00, 1, 0);
    chk("busy_start_err", 64'({error, busy}), 64'b11);
    wait_rd(5, cyc);
    chk("busy_rd_latency", 64'({cyc[7:0], 8'(wclk_n - w0)}), 64'h0D00);
    @(negedge clk);

    // Reset during the write clock of the second byte
    pulse_start(0, 1, 0, 0, 8'h50, 1, 0);
    chk("rst_wr_req", 64'(wr_word_req), 64'd1);
    wr_word = 32'h11223344;
    repeat (6) @(negedge clk);
    chk("rst_pre_strobe", 64'({ram_we, ram_wr_clock}), 64'b11);
    reset = 1'b1;
    #1;
    chk("rst_async_out", 64'({busy, error, rd_word_valid, rd_done, wr_word_req, wr_done,
                              ram_we, ram_rd_clock, ram_wr_clock, ram_wr_addr, ram_wr_data}), 64'd0);
    repeat (3) @(negedge clk);
    chk("rst_no_done", 64'(wr_done), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_first_byte", 64'(mem[8'h50]), 64'h44);
    exp_q.push_back(32'h44332211);
    pulse_start(1, 0, 8'h10, 1, 0, 0, 0);
    wait_rd(1, cyc);
    chk("post_rst_latency", 64'(cyc), 64'd13);
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
